// File: rtl/filter_frame_scheduler.sv
// -----------------------------------------------------------------------------
// filter_frame_scheduler
//
// Frame-level controller for the median filter engine. Two ping-pong frame
// banks are used: the loader fills loadBank while the filter reads filterBank.
// A run is started on a full bank, the filter's ready/done handshake is
// tracked, and on completion the bank is freed and the filter moves on to the
// other bank. New runs are held back until the result consumer has drained the
// previous output. Completed runs and dropped loader pulses are counted.
//
// Handshake semantics (filter side):
//   filterStart is a one-cycle request. The filter acknowledges by dropping
//   filterReady; if it has not done so within ACK_TIMEOUT cycles of ACK,
//   ackError is set (sticky) and the FSM returns to IDLE with the bank still
//   full, so the run is retried. filterDone is a level; only the first cycle
//   it is seen high in RUN completes the run. A new start needs
//   filterReady=1, so the filter's post-done cycle is never overlapped.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   enable          1 = new runs may be started (in-flight runs always finish)
//   frameLoaded     pulse: loader finished writing bank loadBank
//   outDrained      pulse: consumer finished reading the filter result
//   filterReady     filter idle indicator
//   filterDone      filter completion level
//   filterStart     one-cycle start pulse to the filter
//   filterBank      bank the filter reads
//   loadBank        bank the loader writes
//   loadAllowed     loader may write loadBank
//   resultValid     a filtered frame is pending, not yet drained
//   busy            FSM not in IDLE
//   ackError        sticky: filter failed to acknowledge a start
//   frameCount      completed runs, wraps
//   overrunCount    dropped frameLoaded pulses, saturating
//   debugState      current FSM state (0 IDLE, 1 START, 2 ACK, 3 RUN)
// -----------------------------------------------------------------------------
module filter_frame_scheduler #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16,
    parameter int OVR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frameLoaded,
    input  logic             outDrained,
    input  logic             filterReady,
    input  logic             filterDone,
    output logic             filterStart,
    output logic             filterBank,
    output logic             loadBank,
    output logic             loadAllowed,
    output logic             resultValid,
    output logic             busy,
    output logic             ackError,
    output logic [CNT_W-1:0] frameCount,
    output logic [OVR_W-1:0] overrunCount,
    output logic [1:0]       debugState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state;
    logic [1:0]       bankFull;
    logic [ACK_W-1:0] ackCnt;

    logic             runDone;
    logic             loadAccept;
    logic [1:0]       bankFullNext;

    // Both are pure functions of registered state, so they change only on
    // clock edges (or reset) just like the registered outputs.
    assign loadAllowed = ~bankFull[loadBank];
    assign busy        = (state != IDLE);
    assign debugState  = state;

    // Leaving RUN on the same edge guarantees a held filterDone level is
    // acted on exactly once per run.
    assign runDone    = (state == RUN) && filterDone;

    // Acceptance uses the pre-clear occupancy: a bank freed on this edge only
    // becomes loadable on the next cycle.
    assign loadAccept = frameLoaded && loadAllowed;

    // A set and a clear can never hit the same bank: the loader only writes an
    // empty bank and the filter only frees a full one.
    always_comb begin
        bankFullNext = bankFull;
        if (loadAccept) begin
            bankFullNext[loadBank] = 1'b1;
        end
        if (runDone) begin
            bankFullNext[filterBank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bankFull     <= 2'b00;
            loadBank     <= 1'b0;
            filterBank   <= 1'b0;
            filterStart  <= 1'b0;
            resultValid  <= 1'b0;
            ackError     <= 1'b0;
            frameCount   <= '0;
            overrunCount <= '0;
            ackCnt       <= '0;
        end else begin
            bankFull <= bankFullNext;

            if (loadAccept) begin
                loadBank <= ~loadBank;
            end else if (frameLoaded && (overrunCount != '1)) begin
                overrunCount <= overrunCount + OVR_W'(1);
            end

            // A completion in RUN below overrides this, so a drain pulse in
            // the completion cycle cannot swallow the new result.
            if (outDrained) begin
                resultValid <= 1'b0;
            end

            filterStart <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && bankFull[filterBank] && filterReady && !resultValid) begin
                        state       <= START;
                        filterStart <= 1'b1;
                    end
                end

                START: begin
                    ackCnt <= '0;
                    state  <= ACK;
                end

                ACK: begin
                    if (!filterReady) begin
                        state <= RUN;
                    end else if (ackCnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        // Bank stays full, so IDLE will retry the same bank.
                        ackError <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        ackCnt <= ackCnt + ACK_W'(1);
                    end
                end

                RUN: begin
                    if (filterDone) begin
                        filterBank  <= ~filterBank;
                        resultValid <= 1'b1;
                        frameCount  <= frameCount + CNT_W'(1);
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
